pop_pulse_sequencer: RTL
========================

POP_PULSE_SEQUENCER -- requirements
Module: pop_pulse_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: width of the period counter and all timing registers.
REQ-002 Parameter NCH, default 4: number of independent pulse channels (1..16).
REQ-003 Parameter DEF_PERIOD, default 45000: period register reset value, in clocks.
REQ-004 clk_2M5  input  1  sole clock, 2.5 MHz, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  level; continuous-mode run request.
REQ-007 oneshot  input  1  level; mode select, sampled only on IDLE->RUN.
REQ-008 trigger  input  1  one-clock pulse; starts one-shot period.
REQ-009 abort  input  1  one-clock pulse; forces IDLE.
REQ-010 wr_en  input  1  register write strobe.
REQ-011 wr_sel  input  8  register select: 0=period, 2k+1=start of ch k, 2k+2=stop of ch k.
REQ-012 wr_data  input  WIDTH  write data.
REQ-013 out_ch  output  NCH  registered channel pulses (pump/MW/probe/sample etc.).
REQ-014 count  output  WIDTH  current period count.
REQ-015 busy  output  1  high in RUN.
REQ-016 cycle_start  output  1  high for exactly the clock in which count==0 in RUN.
REQ-017 done  output  1  one-clock pulse on one-shot completion.

Function
REQ-018 Two states, IDLE and RUN; in IDLE count=0, out_ch=0, busy=0.
REQ-019 IDLE->RUN when (run & !oneshot) or (trigger & oneshot); latched mode = oneshot; count starts at 0.
REQ-020 RUN: count increments by 1 per clock; when count >= period-1, count <= 0 next clock (covers period lowered below count).
REQ-021 Period values 0 and 1 are treated as 2.
REQ-022 Continuous mode: RUN->IDLE on the clock after run is sampled low, or on abort.
REQ-023 One-shot mode: run ignored; RUN->IDLE on the wrap clock; done=1 in the first IDLE clock; trigger during RUN ignored.
REQ-024 abort has priority over every other transition, including simultaneous trigger/wrap; abort never produces done.
REQ-025 out_ch[k] <= RUN & (start_k <= count) & (count < stop_k); one-clock latency from count to output.
REQ-026 start_k >= stop_k, or start_k >= period: channel k never asserts; pulses never wrap across the period boundary.
REQ-027 Writes with wr_sel > 2*NCH are ignored; all compares are unsigned, WIDTH bits, no overflow possible.

Reset
REQ-028 On reset: state IDLE, count=0, out_ch=0, busy=0, cycle_start=0, done=0, period=DEF_PERIOD, all start/stop=0 (all channels off).
REQ-029 reset mid-RUN clears outputs asynchronously; no done pulse is generated.

Configuration
REQ-030 Macro POP_SEQ_SHADOW_EN defined: writes land in shadow registers; shadow copied to active on the RUN wrap clock and every IDLE clock; a write on the wrap clock takes effect for the new period.
REQ-031 POP_SEQ_SHADOW_EN undefined: writes update active registers directly, effective from the next clock, including mid-period.

Verification
REQ-032 period=10, ch0 start=2 stop=5, run=1 continuous -> out_ch[0] high while count=3,4,5 every period; cycle_start each 10 clocks.
REQ-033 oneshot=1, trigger, period=10 -> busy for 10 clocks, one done pulse, count returns 0; second trigger repeats exactly.
REQ-034 ch1 start=7 stop=3 and ch2 start=12 (period 10) -> ch1 and ch2 never assert over 3 periods.
REQ-035 abort at count=4 with simultaneous trigger -> IDLE next clock, out_ch=0, no done, no restart.
REQ-036 Write period=6 at count=7 (period 10): shadow build -> wraps at 9, next period 6; non-shadow build -> count 0 next clock.
REQ-037 reset asserted mid-pulse asynchronously -> out_ch=0 before next edge, registers at defaults.

Source files
------------

// File: rtl/pop_pulse_sequencer_if.sv
// Control, register-write and pulse-output bundle of the pulse sequencer.
// master: the controller driving run/trigger/writes; slave: the sequencer.
interface pop_pulse_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NCH   = 4
);
    logic             run;
    logic             oneshot;
    logic             trigger;
    logic             abort;
    logic             wr_en;
    logic [7:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [NCH-1:0]   out_ch;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             cycle_start;
    logic             done;

    modport master (
        output run, oneshot, trigger, abort, wr_en, wr_sel, wr_data,
        input  out_ch, count, busy, cycle_start, done
    );

    modport slave (
        input  run, oneshot, trigger, abort, wr_en, wr_sel, wr_data,
        output out_ch, count, busy, cycle_start, done
    );
endinterface

// File: rtl/pop_pulse_sequencer.sv
// Multi-channel periodic pulse sequencer (continuous or one-shot periods).
// Each channel k is high while start_k <= count < stop_k, one clock after the count.
// Build macro POP_SEQ_SHADOW_EN: timing writes go to shadow registers that are
// copied to the active set on every IDLE clock and on the RUN wrap clock.
module pop_pulse_sequencer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NCH        = 4,
    parameter int unsigned DEF_PERIOD = 45000
) (
    input logic                  clk_2M5,
    input logic                  reset,
    pop_pulse_sequencer_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;
    logic   mode_q, mode_d;  // 1: one-shot period, 0: continuous

    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] start_q [NCH];
    logic [WIDTH-1:0] start_d [NCH];
    logic [WIDTH-1:0] stop_q  [NCH];
    logic [WIDTH-1:0] stop_d  [NCH];

    logic             period_wr;
    logic [NCH-1:0]   start_wr, stop_wr;

    logic [WIDTH-1:0] eff_period;
    logic             wrap;
    logic             stay_run;

    logic [WIDTH-1:0] count_q, count_d;
    logic [NCH-1:0]   out_ch_q, out_ch_d;
    logic             done_q, done_d;

    // Periods below 2 behave as 2; '>=' also catches a period lowered under the count.
    assign eff_period = (period_q < WIDTH'(2)) ? WIDTH'(2) : period_q;
    assign wrap       = (state_q == StRun) && (count_q >= eff_period - WIDTH'(1));

    // Register select decode; selects beyond the last channel match nothing.
    always_comb begin
        period_wr = bus.wr_en && (bus.wr_sel == 8'd0);
        start_wr  = '0;
        stop_wr   = '0;
        for (int k = 0; k < NCH; k++) begin
            start_wr[k] = bus.wr_en && (bus.wr_sel == 8'(2 * k + 1));
            stop_wr[k]  = bus.wr_en && (bus.wr_sel == 8'(2 * k + 2));
        end
    end

`ifdef POP_SEQ_SHADOW_EN
    logic [WIDTH-1:0] period_sh_q, period_w;
    logic [WIDTH-1:0] start_sh_q [NCH];
    logic [WIDTH-1:0] start_w    [NCH];
    logic [WIDTH-1:0] stop_sh_q  [NCH];
    logic [WIDTH-1:0] stop_w     [NCH];
    logic             load;

    // A write on the wrap clock bypasses the shadow so it applies to the new period.
    assign load = (state_q == StIdle) || wrap;

    // Shadow next values and conditional transfer to the active set.
    always_comb begin
        period_w = period_wr ? bus.wr_data : period_sh_q;
        period_d = load ? period_w : period_q;
        start_w  = start_sh_q;
        stop_w   = stop_sh_q;
        start_d  = start_q;
        stop_d   = stop_q;
        for (int k = 0; k < NCH; k++) begin
            if (start_wr[k]) start_w[k] = bus.wr_data;
            if (stop_wr[k])  stop_w[k]  = bus.wr_data;
            if (load) begin
                start_d[k] = start_w[k];
                stop_d[k]  = stop_w[k];
            end
        end
    end

    // Shadow register bank.
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            period_sh_q <= WIDTH'(DEF_PERIOD);
            for (int k = 0; k < NCH; k++) begin
                start_sh_q[k] <= '0;
                stop_sh_q[k]  <= '0;
            end
        end else begin
            period_sh_q <= period_w;
            for (int k = 0; k < NCH; k++) begin
                start_sh_q[k] <= start_w[k];
                stop_sh_q[k]  <= stop_w[k];
            end
        end
    end
`else
    // Writes go straight to the active registers, even mid-period.
    always_comb begin
        period_d = period_wr ? bus.wr_data : period_q;
        start_d  = start_q;
        stop_d   = stop_q;
        for (int k = 0; k < NCH; k++) begin
            if (start_wr[k]) start_d[k] = bus.wr_data;
            if (stop_wr[k])  stop_d[k]  = bus.wr_data;
        end
    end
`endif

    // Active timing registers; reset leaves every channel off.
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            period_q <= WIDTH'(DEF_PERIOD);
            for (int k = 0; k < NCH; k++) begin
                start_q[k] <= '0;
                stop_q[k]  <= '0;
            end
        end else begin
            period_q <= period_d;
            for (int k = 0; k < NCH; k++) begin
                start_q[k] <= start_d[k];
                stop_q[k]  <= stop_d[k];
            end
        end
    end

    // FSM state register, including the mode latched on entry to RUN.
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // FSM next state; abort outranks every other transition.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.abort && ((bus.run && !bus.oneshot) || (bus.trigger && bus.oneshot))) begin
                    state_d = StRun;
                    mode_d  = bus.oneshot;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (mode_q) begin
                    if (wrap) state_d = StIdle;
                end else if (!bus.run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values; outputs are forced low on any clock that leaves or enters RUN.
    always_comb begin
        stay_run = (state_q == StRun) && (state_d == StRun);
        count_d  = '0;
        if (stay_run && !wrap) count_d = count_q + WIDTH'(1);
        out_ch_d = '0;
        for (int k = 0; k < NCH; k++) begin
            out_ch_d[k] = stay_run && (start_q[k] <= count_q) && (count_q < stop_q[k]) &&
                          (start_q[k] < eff_period);
        end
        done_d = mode_q && wrap && !bus.abort;
    end

    // Datapath registers.
    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            out_ch_q <= '0;
            done_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            out_ch_q <= out_ch_d;
            done_q   <= done_d;
        end
    end

    // FSM and datapath outputs.
    always_comb begin
        bus.busy        = (state_q == StRun);
        bus.cycle_start = (state_q == StRun) && (count_q == '0);
        bus.count       = count_q;
        bus.out_ch      = out_ch_q;
        bus.done        = done_q;
    end
endmodule
